// File: rtl/yin_frame_scheduler.sv
// yin_frame_scheduler
//   Runs the YIN pitch engine on a live sample stream. Incoming samples are
//   buffered in a FIFO and forwarded to the engine only while it is idle. A
//   start is issued once a full window has been forwarded, and after that
//   every HOP samples. If the engine does not answer, it is soft-reset and
//   the window is refilled. Results pass through an unvoiced-hold filter
//   before they appear on pitch_out.
//
// Ports
//   clk_in, rst_in                 clock, asynchronous active-high reset
//   sig_in, sig_in_valid           incoming samples (at most one per cycle)
//   en_in                          1 allows new starts; forwarding always runs
//   eng_sig_out, eng_sig_valid_out sample stream to the engine (registered)
//   eng_start_out                  engine start_computation, 1-cycle pulse
//   eng_rst_out                    engine soft reset, 1-cycle pulse on timeout
//   eng_f_in, eng_f_valid_in       engine result (16.16 pitch) and strobe
//   pitch_out, pitch_valid_out     smoothed pitch and its update pulse
//   busy_out                       engine started or computing
//   overflow_out, timeout_out      sticky error flags, cleared only by reset

module yin_frame_scheduler #(
  parameter int unsigned SIG_WIDTH      = 9,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned WINDOW_SIZE    = 500,
  parameter int unsigned HOP            = 250,
  parameter int unsigned FIFO_DEPTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned HOLD_FRAMES    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [SIG_WIDTH-1:0] sig_in,
  input  logic                 sig_in_valid,
  input  logic                 en_in,
  output logic [SIG_WIDTH-1:0] eng_sig_out,
  output logic                 eng_sig_valid_out,
  output logic                 eng_start_out,
  output logic                 eng_rst_out,
  input  logic [WIDTH-1:0]     eng_f_in,
  input  logic                 eng_f_valid_in,
  output logic [WIDTH-1:0]     pitch_out,
  output logic                 pitch_valid_out,
  output logic                 busy_out,
  output logic                 overflow_out,
  output logic                 timeout_out
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCW     = AW + 1;
  localparam int unsigned CNT_MAX = (WINDOW_SIZE > HOP) ? WINDOW_SIZE : HOP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned MW      = $clog2(HOLD_FRAMES + 2);

  localparam logic [CW-1:0]  WIN_CNT   = CW'(WINDOW_SIZE);
  localparam logic [CW-1:0]  HOP_CNT   = CW'(HOP);
  localparam logic [TW-1:0]  TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FCW-1:0] FIFO_FULL = FCW'(FIFO_DEPTH);
  localparam logic [MW-1:0]  HOLD_MAX  = MW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_START,
    S_WAIT
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [SIG_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [FCW-1:0]       fifo_cnt;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign empty = (fifo_cnt == '0);
  assign full  = (fifo_cnt == FIFO_FULL);
  // A pop in the same cycle frees the slot, so a push on full still fits.
  assign push  = sig_in_valid && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= sig_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (sig_in_valid && full && !pop) begin
        overflow_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [CW-1:0] target;
  logic [TW-1:0] tmr;
  logic          go_start;
  logic          accept;
  logic          expire;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    target        = (state == S_FILL) ? WIN_CNT : HOP_CNT;
    go_start      = 1'b0;
    accept        = 1'b0;
    expire        = 1'b0;
    eng_start_out = 1'b0;
    eng_rst_out   = 1'b0;
    busy_out      = 1'b0;
    case (state)
      S_FILL, S_RUN: begin
        if ((cnt == target) && en_in) begin
          go_start   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: begin
        eng_start_out = 1'b1;
        busy_out      = 1'b1;
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        busy_out = 1'b1;
        // A result arriving in the timeout cycle is still taken.
        if (eng_f_valid_in) begin
          accept     = 1'b1;
          state_next = S_RUN;
        end else if (tmr == TMR_LAST) begin
          expire      = 1'b1;
          eng_rst_out = 1'b1;
          state_next  = S_FILL;
        end
      end
      default: state_next = S_FILL;
    endcase
    // The cycle that decides to start sends nothing, which keeps the
    // registered sample strobe away from the start pulse.
    pop = ((state == S_FILL) || (state == S_RUN)) && !empty && !go_start;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt               <= '0;
      tmr               <= '0;
      eng_sig_out       <= '0;
      eng_sig_valid_out <= 1'b0;
      timeout_out       <= 1'b0;
    end else begin
      eng_sig_valid_out <= pop;
      if (pop) begin
        eng_sig_out <= mem[rd_ptr];
      end
      // With starts disabled the count parks at the target while samples
      // keep flowing, so a start follows as soon as en_in returns.
      if (accept || expire) begin
        cnt <= '0;
      end else if (pop && (cnt != target)) begin
        cnt <= cnt + 1'b1;
      end
      if (state == S_START) begin
        tmr <= '0;
      end else if (state == S_WAIT) begin
        tmr <= tmr + 1'b1;
      end
      if (expire) begin
        timeout_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Unvoiced-hold smoothing
  // ---------------------------------------------------------------------
  logic [MW-1:0] miss_cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pitch_out       <= '0;
      pitch_valid_out <= 1'b0;
      miss_cnt        <= '0;
    end else begin
      pitch_valid_out <= accept;
      if (accept) begin
        if (eng_f_in != '0) begin
          pitch_out <= eng_f_in;
          miss_cnt  <= '0;
        end else if (miss_cnt < HOLD_MAX) begin
          miss_cnt <= miss_cnt + 1'b1;
        end else begin
          pitch_out <= '0;
        end
      end
    end
  end

endmodule
